// File: rtl/reg_bank_8088.sv
// 8088-style register bank: eight 16-bit registers with byte/word writes and
// two registered, write-first read ports sharing a one-cycle valid pulse.
module reg_bank_8088 (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic        WAL,
   input  logic        WAH,
   input  logic        WBL,
   input  logic        WBH,
   input  logic        WCL,
   input  logic        WCH,
   input  logic        WDL,
   input  logic        WDH,
   input  logic        WSP,
   input  logic        WBP,
   input  logic        WDI,
   input  logic        WSI,
   input  logic [15:0] din,
   input  logic        rd_en,
   input  logic [3:0]  rd_sel_a,
   input  logic [3:0]  rd_sel_b,
   output logic [15:0] dout_a,
   output logic [15:0] dout_b,
   output logic        dout_valid,
   output logic        wr_err
);

   // Register index follows the word-select encoding: AX CX DX BX SP BP SI DI.
   logic [7:0][15:0] regs_q, regs_d;
   logic [7:0]       wl, wh, hit;
   logic             legal, wr_go;
   logic [15:0]      dout_a_q, dout_a_d, dout_b_q, dout_b_d;
   logic             dout_valid_q, wr_err_q;

   function automatic logic [15:0] rd_mux(input logic [7:0][15:0] r, input logic [3:0] s);
      logic [15:0] w;
      w = r[{1'b0, s[1:0]}];
      if (s[3])      rd_mux = r[s[2:0]];
      else if (s[2]) rd_mux = {8'h00, w[15:8]};
      else           rd_mux = {8'h00, w[7:0]};
   endfunction

   always_comb begin
      wl    = {WDI, WSI, WBP, WSP, WBL, WDL, WCL, WAL};
      wh    = {WDI, WSI, WBP, WSP, WBH, WDH, WCH, WAH};
      hit   = wl | wh;
      // Exactly one register touched is legal; zero or several is an error.
      legal = $onehot(hit);
      wr_go = we & legal;
      regs_d = regs_q;
      for (int i = 0; i < 8; i++) begin
         if (wr_go && wl[i]) regs_d[i][7:0] = din[7:0];
         // A lone high-byte write takes its data from din[7:0].
         if (wr_go && wh[i]) regs_d[i][15:8] = wl[i] ? din[15:8] : din[7:0];
      end
      // Reads look at next-state so a same-edge write is visible.
      dout_a_d = rd_en ? rd_mux(regs_d, rd_sel_a) : dout_a_q;
      dout_b_d = rd_en ? rd_mux(regs_d, rd_sel_b) : dout_b_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         regs_q       <= '0;
         dout_a_q     <= '0;
         dout_b_q     <= '0;
         dout_valid_q <= 1'b0;
         wr_err_q     <= 1'b0;
      end else begin
         regs_q       <= regs_d;
         dout_a_q     <= dout_a_d;
         dout_b_q     <= dout_b_d;
         dout_valid_q <= rd_en;
         wr_err_q     <= wr_err_q | (we & ~legal);
      end
   end

   assign dout_a     = dout_a_q;
   assign dout_b     = dout_b_q;
   assign dout_valid = dout_valid_q;
   assign wr_err     = wr_err_q;

endmodule

// File: tb/tb_reg_bank_8088.sv
// Scoreboard bench for reg_bank_8088: reads push expected data, a negedge
// monitor pops and compares whenever dout_valid is presented.
module tb_reg_bank_8088;

   logic        clk = 1'b0;
   logic        rst, we, rd_en;
   logic [11:0] en;   // {WAL,WAH,WBL,WBH,WCL,WCH,WDL,WDH,WSP,WBP,WDI,WSI}
   logic [15:0] din;
   logic [3:0]  rd_sel_a, rd_sel_b;
   logic [15:0] dout_a, dout_b;
   logic        dout_valid, wr_err;

   int tests = 0;
   int fails = 0;
   logic [31:0] exp_q[$];

   localparam logic [11:0] E_AL = 12'b1000_0000_0000, E_AH = 12'b0100_0000_0000;
   localparam logic [11:0] E_BL = 12'b0010_0000_0000, E_BH = 12'b0001_0000_0000;
   localparam logic [11:0] E_CL = 12'b0000_1000_0000, E_CH = 12'b0000_0100_0000;
   localparam logic [11:0] E_DL = 12'b0000_0010_0000, E_DH = 12'b0000_0001_0000;
   localparam logic [11:0] E_SP = 12'b0000_0000_1000, E_BP = 12'b0000_0000_0100;
   localparam logic [11:0] E_DI = 12'b0000_0000_0010, E_SI = 12'b0000_0000_0001;

   always #5 clk = ~clk;

   reg_bank_8088 dut (
      .clk(clk), .rst(rst), .we(we),
      .WAL(en[11]), .WAH(en[10]), .WBL(en[9]), .WBH(en[8]),
      .WCL(en[7]), .WCH(en[6]), .WDL(en[5]), .WDH(en[4]),
      .WSP(en[3]), .WBP(en[2]), .WDI(en[1]), .WSI(en[0]),
      .din(din), .rd_en(rd_en), .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b),
      .dout_a(dout_a), .dout_b(dout_b), .dout_valid(dout_valid), .wr_err(wr_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Monitor: every valid output must match the oldest outstanding read.
   always @(negedge clk) begin
      if (dout_valid) begin
         if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_valid: got %h/%h, expected no valid", dout_a, dout_b);
         end else begin
            chk("read_data", {dout_a, dout_b}, exp_q.pop_front());
         end
      end
   end

   task automatic idle();
      rst = 0; we = 0; en = '0; din = '0; rd_en = 0; rd_sel_a = '0; rd_sel_b = '0;
   endtask

   task automatic tick();
      @(posedge clk); #1; idle();
   endtask

   task automatic wr(input logic [11:0] e, input logic [15:0] d);
      we = 1; en = e; din = d; tick();
   endtask

   task automatic rd(input logic [3:0] sa, input logic [3:0] sb,
                     input logic [15:0] ea, input logic [15:0] eb);
      rd_en = 1; rd_sel_a = sa; rd_sel_b = sb; exp_q.push_back({ea, eb}); tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      idle();
      rst = 1; tick(); rst = 1; tick();
      chk("rst_valid", dout_valid, 0);
      chk("rst_wr_err", wr_err, 0);
      chk("rst_dout", {dout_a, dout_b}, 0);

      // Reset contents, then holding with rd_en=0
      rd(4'b1000, 4'b1111, 16'h0000, 16'h0000);
      tick();
      chk("valid_one_cycle", dout_valid, 0);

      // Word then high-byte write
      wr(E_AL | E_AH, 16'h1234);
      wr(E_AH, 16'h00FF);
      rd(4'b1000, 4'b0100, 16'hFF34, 16'h00FF);
      rd(4'b0000, 4'b0100, 16'h0034, 16'h00FF);
      tick();
      chk("hold_dout", {dout_a, dout_b}, {16'h0034, 16'h00FF});

      // Write-first on SP
      we = 1; en = E_SP; din = 16'hBEEF;
      rd_en = 1; rd_sel_a = 4'b1100; rd_sel_b = 4'b0000;
      exp_q.push_back({16'hBEEF, 16'h0034}); tick();

      // Byte writes on CX, high byte written while low byte is read
      wr(E_CL, 16'hAB12);
      rd(4'b0001, 4'b1001, 16'h0012, 16'h0012);
      we = 1; en = E_CH; din = 16'h77CD;
      rd_en = 1; rd_sel_a = 4'b0001; rd_sel_b = 4'b1001;
      exp_q.push_back({16'h0012, 16'hCD12}); tick();
      rd(4'b0101, 4'b0101, 16'h00CD, 16'h00CD);

      // we=0 ignores enables
      en = E_DI; din = 16'h9999; tick();
      rd(4'b1111, 4'b1111, 16'h0000, 16'h0000);
      chk("we0_wr_err", wr_err, 0);

      // Remaining registers, mixed byte/word
      wr(E_DL | E_DH, 16'h4321);
      wr(E_BH, 16'h5A5A);
      wr(E_BP, 16'hCAFE);
      wr(E_SI, 16'h1357);
      wr(E_DI, 16'h2468);
      rd(4'b1010, 4'b1011, 16'h4321, 16'h5A00);
      rd(4'b1101, 4'b1110, 16'hCAFE, 16'h1357);
      rd(4'b1111, 4'b0110, 16'h2468, 16'h0043);
      rd(4'b0011, 4'b0111, 16'h0000, 16'h005A);

      // Reset overrides a same-edge write and read
      wr(E_CL | E_CH, 16'hABCD);
      rd(4'b1001, 4'b0001, 16'hABCD, 16'h00CD);
      rst = 1; we = 1; en = E_CL; din = 16'h0011; rd_en = 1; rd_sel_a = 4'b1001; tick();
      chk("valid_after_rst", dout_valid, 0);
      rd(4'b1001, 4'b1100, 16'h0000, 16'h0000);

      // Two registers at once is illegal and sticky
      wr(E_AL | E_BL, 16'h5555);
      chk("illegal_sets_err", wr_err, 1);
      rd(4'b1000, 4'b1011, 16'h0000, 16'h0000);
      repeat (10) tick();
      chk("err_sticky", wr_err, 1);
      rst = 1; tick();
      chk("err_cleared", wr_err, 0);

      // Zero enables with we=1 is illegal
      wr(12'h000, 16'h1111);
      chk("zero_en_err", wr_err, 1);
      rst = 1; tick();

      // SP+BP and AL+SP are illegal; nothing written
      wr(E_SP | E_BP, 16'h7777);
      chk("sp_bp_err", wr_err, 1);
      wr(E_AL | E_SP, 16'h8888);
      rd(4'b1100, 4'b1000, 16'h0000, 16'h0000);
      rd(4'b1101, 4'b0000, 16'h0000, 16'h0000);

      repeat (3) tick();
      chk("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/reg_bank_8088.md
REG_BANK_8088 -- requirements
Module: reg_bank_8088

Interface
REQ-001: The block SHALL use one clock, clk; reset, rst, SHALL be synchronous and active-high.
REQ-002: clk  input  1  rising-edge clock for all state.
REQ-003: rst  input  1  synchronous active-high reset.
REQ-004: we  input  1  write strobe that qualifies the write-enable lines.
REQ-005: WAL, WAH, WBL, WBH, WCL, WCH, WDL, WDH, WSP, WBP, WDI, WSI  input  1 each  per-register/byte write enables from the bank-selection decoder.
REQ-006: din  input  16  write data.
REQ-007: rd_en  input  1  read request.
REQ-008: rd_sel_a, rd_sel_b  input  4 each  read selects. Encoding:
- 0000 AL, 0001 CL, 0010 DL, 0011 BL
- 0100 AH, 0101 CH, 0110 DH, 0111 BH
- 1000 AX, 1001 CX, 1010 DX, 1011 BX
- 1100 SP, 1101 BP, 1110 SI, 1111 DI
REQ-009: dout_a, dout_b  output  16 each  registered read data.
REQ-010: dout_valid  output  1  one-cycle pulse marking new read data.
REQ-011: wr_err  output  1  sticky flag for an illegal enable combination.

Function
REQ-012: The block SHALL hold eight 16-bit registers: AX, BX, CX, DX, SP, BP, SI, DI.
REQ-013: Writes SHALL happen only on a rising edge where we=1 and rst=0. With we=0, all enables SHALL be ignored.
REQ-014: A single-byte write with exactly one of WxL/WxH asserted SHALL write din[7:0] into the selected byte. The other byte SHALL be unchanged, and din[15:8] SHALL be ignored.
REQ-015: A word write SHALL write din[15:0]. A word write is either WxL and WxH asserted together for the same register, or exactly one of WSP/WBP/WSI/WDI asserted.
REQ-016: Any other combination with we=1 SHALL be illegal: zero enables, or two or more registers. An illegal combination SHALL write nothing and SHALL set wr_err to 1 on that edge.
REQ-017: wr_err SHALL stay at 1 until rst.
REQ-018: Reads SHALL have one-cycle latency. When rd_en=1 at edge N, dout_a and dout_b SHALL show the selected values after edge N, and dout_valid SHALL be 1 for exactly that cycle.
REQ-019: Byte selects (0000-0111) SHALL return the byte zero-extended to 16 bits. Word selects (1000-1111) SHALL return the full register.
REQ-020: Reads SHALL be write-first: a legal write at edge N to a register or byte being read at edge N SHALL be reflected in dout at N+1.
REQ-021: A read SHALL be unaffected by a write to the other byte of the same register, apart from that byte's value appearing in word reads.
REQ-022: With rd_en=0, dout_a/dout_b SHALL hold their previous values and dout_valid SHALL be 0.
REQ-023: rd_sel_a and rd_sel_b SHALL be independent and MAY select the same register.
REQ-024: The block SHALL contain no other state machine. Back-to-back writes and reads on every cycle SHALL be supported with no stall.

Reset
REQ-025: rst=1 at an edge SHALL clear all eight registers, dout_a, dout_b, dout_valid and wr_err to 0.
REQ-026: rst SHALL take priority over we and rd_en on the same edge; that write and that read SHALL be discarded.
REQ-027: After rst deasserts, the first edge with we or rd_en SHALL operate normally with no extra delay.

Verification
REQ-028: Sequence:
- rst, then rd_en=1 with rd_sel_a=1000, rd_sel_b=1111.
- Required: dout_a=0000, dout_b=0000, dout_valid=1 for one cycle.
REQ-029: Sequence:
- we=1, WAL=WAH=1, din=1234.
- Next cycle: we=1, WAH=1, din=00FF.
- Then read 1000/0100.
- Required: dout_a=FF34, dout_b=00FF.
REQ-030: Sequence:
- we=1, WSP=1, din=BEEF, together with rd_en=1, rd_sel_a=1100 on the same edge.
- Required: dout_a=BEEF on the next cycle (write-first).
REQ-031: Sequence:
- we=1, WAL=WBL=1, din=5555.
- Required: wr_err=1, AX=BX=0 on read, wr_err still 1 ten cycles later.
- Then rst: wr_err=0.
REQ-032: Sequence:
- Load CX=ABCD.
- Assert rst together with we=1, WCL=1, din=0011 and rd_en=1.
- Required: CX=0000 on a later read, dout_valid=0 in the cycle after reset.
REQ-033: Sequence:
- we=0 with WDI=1, din=9999.
- Required: DI stays 0000 and wr_err stays 0.
